// File: rtl/exe_issue_decoder.sv
// Decode/issue stage: turns instruction words into registered ALU commands,
// stalling on register hazards tracked by a writeback-cleared scoreboard.
package exe_defs_pkg;
  localparam int WORD_LEN = 32;

  typedef enum logic [3:0] {
    EXE_ADD = 4'd0,
    EXE_SUB = 4'd1,
    EXE_AND = 4'd2,
    EXE_OR  = 4'd3,
    EXE_XOR = 4'd4,
    EXE_NOR = 4'd5,
    EXE_SLA = 4'd6,
    EXE_SLL = 4'd7,
    EXE_SRA = 4'd8,
    EXE_SRL = 4'd9
  } execmd_t;
endpackage

module exe_issue_decoder #(
  parameter int WORD_LEN  = exe_defs_pkg::WORD_LEN,
  parameter int INSTR_LEN = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [INSTR_LEN-1:0]   instr,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [WORD_LEN-1:0]    rs1_data,
  input  logic [WORD_LEN-1:0]    rs2_data,
  output logic                   exe_valid,
  input  logic                   exe_ready,
  output exe_defs_pkg::execmd_t  EXE_CMD,
  output logic [WORD_LEN-1:0]    val1,
  output logic [WORD_LEN-1:0]    val2,
  output logic [4:0]             exe_dest,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_addr,
  output logic                   illegal_op
);
  import exe_defs_pkg::*;

  typedef enum logic [1:0] {V2_REG, V2_SEXT, V2_ZEXT, V2_SHAMT} v2sel_t;

  logic [5:0]           opcode;
  logic [4:0]           rd, rs1, rs2;
  logic [15:0]          imm;
  logic                 is_reg, is_imm, is_nop, is_illegal;
  execmd_t              cmd;
  v2sel_t               v2sel;
  logic [WORD_LEN-1:0]  rs1_val, rs2_val, val2_d;
  logic [REG_COUNT-1:0] sb, sb_nxt;
  logic                 hazard, accept, issue;

  assign opcode   = instr[31:26];
  assign rd       = instr[25:21];
  assign rs1      = instr[20:16];
  assign rs2      = instr[15:11];
  assign imm      = instr[15:0];
  assign rs1_addr = rs1;
  assign rs2_addr = rs2;

  always_comb begin
    is_reg = 1'b0;
    is_imm = 1'b0;
    is_nop = 1'b0;
    cmd    = EXE_ADD;
    v2sel  = V2_REG;
    case (opcode)
      6'h00: is_nop = 1'b1;
      6'h01: begin is_reg = 1'b1; cmd = EXE_ADD; end
      6'h02: begin is_reg = 1'b1; cmd = EXE_SUB; end
      6'h03: begin is_reg = 1'b1; cmd = EXE_AND; end
      6'h04: begin is_reg = 1'b1; cmd = EXE_OR;  end
      6'h05: begin is_reg = 1'b1; cmd = EXE_XOR; end
      6'h06: begin is_reg = 1'b1; cmd = EXE_NOR; end
      6'h07: begin is_reg = 1'b1; cmd = EXE_SLA; end
      6'h08: begin is_reg = 1'b1; cmd = EXE_SLL; end
      6'h09: begin is_reg = 1'b1; cmd = EXE_SRA; end
      6'h0A: begin is_reg = 1'b1; cmd = EXE_SRL; end
      6'h21: begin is_imm = 1'b1; cmd = EXE_ADD; v2sel = V2_SEXT;  end
      6'h22: begin is_imm = 1'b1; cmd = EXE_SUB; v2sel = V2_SEXT;  end
      6'h23: begin is_imm = 1'b1; cmd = EXE_AND; v2sel = V2_ZEXT;  end
      6'h24: begin is_imm = 1'b1; cmd = EXE_OR;  v2sel = V2_ZEXT;  end
      6'h25: begin is_imm = 1'b1; cmd = EXE_XOR; v2sel = V2_ZEXT;  end
      6'h28: begin is_imm = 1'b1; cmd = EXE_SLL; v2sel = V2_SHAMT; end
      6'h29: begin is_imm = 1'b1; cmd = EXE_SRL; v2sel = V2_SHAMT; end
      default: ;
    endcase
  end

  assign is_illegal = ~(is_reg | is_imm | is_nop);

  // r0 reads as zero no matter what the register file returns
  assign rs1_val = (rs1 == 5'd0) ? '0 : rs1_data;
  assign rs2_val = (rs2 == 5'd0) ? '0 : rs2_data;

  always_comb begin
    case (v2sel)
      V2_SEXT:  val2_d = {{(WORD_LEN-16){imm[15]}}, imm};
      V2_ZEXT:  val2_d = {{(WORD_LEN-16){1'b0}}, imm};
      V2_SHAMT: val2_d = {{(WORD_LEN-5){1'b0}}, imm[4:0]};
      default:  val2_d = rs2_val;
    endcase
  end

  // rs2 only matters for register forms; rd covers write-after-write
  assign hazard      = sb[rs1] | (is_reg & sb[rs2]) | sb[rd];
  assign instr_ready = ~hazard & (~exe_valid | exe_ready);
  assign accept      = instr_valid & instr_ready;
  assign issue       = accept & (is_reg | is_imm);

  // Clear first so a same-cycle set on the same bit wins
  always_comb begin
    sb_nxt = sb;
    if (wb_valid) sb_nxt[wb_addr] = 1'b0;
    if (issue && rd != 5'd0) sb_nxt[rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid  <= 1'b0;
      EXE_CMD    <= EXE_ADD;
      val1       <= '0;
      val2       <= '0;
      exe_dest   <= '0;
      illegal_op <= 1'b0;
      sb         <= '0;
    end else begin
      illegal_op <= accept & is_illegal;
      sb         <= sb_nxt;
      if (issue) begin
        exe_valid <= 1'b1;
        EXE_CMD   <= cmd;
        val1      <= rs1_val;
        val2      <= val2_d;
        exe_dest  <= rd;
      end else if (exe_ready) begin
        exe_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exe_issue_decoder.sv
// Self-checking bench for exe_issue_decoder: directed vector table, hand-written
// hazard/stall/reset sequences, then random traffic against a behavioural model.
module tb_exe_issue_decoder;
  import exe_defs_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        instr_valid = 1'b0, exe_ready = 1'b0, wb_valid = 1'b0;
  logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0;
  logic [4:0]  wb_addr = '0;
  logic        instr_ready, exe_valid, illegal_op;
  logic [4:0]  rs1_addr, rs2_addr, exe_dest;
  logic [31:0] val1, val2;
  execmd_t     exe_cmd;

  int checks = 0, failures = 0;

  exe_issue_decoder dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .exe_valid(exe_valid),
    .exe_ready(exe_ready), .EXE_CMD(exe_cmd), .val1(val1), .val2(val2),
    .exe_dest(exe_dest), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  task automatic wb_clear(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    tick();
    wb_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [15:0] lo;
    logic [31:0] d1, d2;
    logic        ev;
    execmd_t     cmd;
    logic [31:0] v1, v2;
    logic        ill;
  } vec_t;

  vec_t vt[20];

  // Reference model: opcode class table plus architectural state
  int          kind[64];   // 0 illegal, 1 nop, 2 reg, 3 sext imm, 4 zext imm, 5 shift imm
  execmd_t     cmdtab[64];
  bit          pend[32];
  logic        m_vld, m_ill;
  execmd_t     m_cmd;
  logic [31:0] m_v1, m_v2;
  logic [4:0]  m_dest;
  logic [5:0]  ops[21];

  initial begin
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [15:0] lo;
    logic        haz, rdy, acc;
    int          k;

    vt[0]  = '{6'h01, 5'd3,  5'd1,  16'h1000, 32'd5,        32'd7,      1'b1, EXE_ADD, 32'd5,        32'd7,        1'b0};
    vt[1]  = '{6'h21, 5'd4,  5'd1,  16'hFFFF, 32'd10,       32'd99,     1'b1, EXE_ADD, 32'd10,       32'hFFFFFFFF, 1'b0};
    vt[2]  = '{6'h23, 5'd4,  5'd1,  16'hFFFF, 32'd10,       32'd99,     1'b1, EXE_AND, 32'd10,       32'h0000FFFF, 1'b0};
    vt[3]  = '{6'h22, 5'd5,  5'd2,  16'h8000, 32'd1,        32'd0,      1'b1, EXE_SUB, 32'd1,        32'hFFFF8000, 1'b0};
    vt[4]  = '{6'h28, 5'd6,  5'd1,  16'h0025, 32'hF0,       32'd0,      1'b1, EXE_SLL, 32'hF0,       32'd5,        1'b0};
    vt[5]  = '{6'h29, 5'd7,  5'd1,  16'hFFE3, 32'h80000000, 32'd0,      1'b1, EXE_SRL, 32'h80000000, 32'd3,        1'b0};
    vt[6]  = '{6'h05, 5'd1,  5'd0,  16'h1000, 32'hDEAD,     32'h55,     1'b1, EXE_XOR, 32'd0,        32'h55,       1'b0};
    vt[7]  = '{6'h09, 5'd2,  5'd1,  16'h0000, 32'h1234,     32'hABCD,   1'b1, EXE_SRA, 32'h1234,     32'd0,        1'b0};
    vt[8]  = '{6'h24, 5'd0,  5'd1,  16'h1234, 32'd3,        32'd0,      1'b1, EXE_OR,  32'd3,        32'h1234,     1'b0};
    vt[9]  = '{6'h06, 5'd9,  5'd10, 16'h5800, 32'hA,        32'hB,      1'b1, EXE_NOR, 32'hA,        32'hB,        1'b0};
    vt[10] = '{6'h25, 5'd8,  5'd3,  16'h8001, 32'd7,        32'd0,      1'b1, EXE_XOR, 32'd7,        32'h8001,     1'b0};
    vt[11] = '{6'h07, 5'd12, 5'd13, 16'h7000, 32'd1,        32'd2,      1'b1, EXE_SLA, 32'd1,        32'd2,        1'b0};
    vt[12] = '{6'h02, 5'd13, 5'd14, 16'h7800, 32'd100,      32'd1,      1'b1, EXE_SUB, 32'd100,      32'd1,        1'b0};
    vt[13] = '{6'h03, 5'd14, 5'd15, 16'h8000, 32'hF0F0,     32'hFF00,   1'b1, EXE_AND, 32'hF0F0,     32'hFF00,     1'b0};
    vt[14] = '{6'h04, 5'd15, 5'd16, 16'h8800, 32'h1,        32'h2,      1'b1, EXE_OR,  32'h1,        32'h2,        1'b0};
    vt[15] = '{6'h08, 5'd16, 5'd17, 16'h9000, 32'h3,        32'h4,      1'b1, EXE_SLL, 32'h3,        32'h4,        1'b0};
    vt[16] = '{6'h0A, 5'd17, 5'd18, 16'h9800, 32'h5,        32'h6,      1'b1, EXE_SRL, 32'h5,        32'h6,        1'b0};
    vt[17] = '{6'h00, 5'd0,  5'd0,  16'h0000, 32'd0,        32'd0,      1'b0, EXE_ADD, 32'd0,        32'd0,        1'b0};
    vt[18] = '{6'h3F, 5'd0,  5'd0,  16'h0000, 32'd0,        32'd0,      1'b0, EXE_ADD, 32'd0,        32'd0,        1'b1};
    vt[19] = '{6'h15, 5'd0,  5'd0,  16'h0000, 32'd0,        32'd0,      1'b0, EXE_ADD, 32'd0,        32'd0,        1'b1};

    for (int i = 0; i < 64; i++) begin kind[i] = 0; cmdtab[i] = EXE_ADD; end
    kind[0] = 1;
    for (int i = 1; i <= 10; i++) begin
      kind[i] = 2;
      cmdtab[i] = execmd_t'(i - 1);
    end
    kind[6'h21] = 3; cmdtab[6'h21] = EXE_ADD;
    kind[6'h22] = 3; cmdtab[6'h22] = EXE_SUB;
    kind[6'h23] = 4; cmdtab[6'h23] = EXE_AND;
    kind[6'h24] = 4; cmdtab[6'h24] = EXE_OR;
    kind[6'h25] = 4; cmdtab[6'h25] = EXE_XOR;
    kind[6'h28] = 5; cmdtab[6'h28] = EXE_SLL;
    kind[6'h29] = 5; cmdtab[6'h29] = EXE_SRL;
    ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
            6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h00, 6'h3F, 6'h15, 6'h2A};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_exe_valid", {31'b0, exe_valid}, 32'd0);
    chk("rst_cmd", 32'(exe_cmd), 32'(EXE_ADD));
    chk("rst_val1", val1, 32'd0);
    chk("rst_val2", val2, 32'd0);
    chk("rst_dest", {27'b0, exe_dest}, 32'd0);
    chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);

    // Directed decode table
    for (int i = 0; i < 20; i++) begin
      instr       = mk(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].lo);
      rs1_data    = vt[i].d1;
      rs2_data    = vt[i].d2;
      instr_valid = 1'b1;
      exe_ready   = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), {31'b0, instr_ready}, 32'd1);
      chk($sformatf("v%0d_rs1_addr", i), {27'b0, rs1_addr}, {27'b0, vt[i].rs1});
      tick();
      instr_valid = 1'b0;
      chk($sformatf("v%0d_exe_valid", i), {31'b0, exe_valid}, {31'b0, vt[i].ev});
      chk($sformatf("v%0d_illegal", i), {31'b0, illegal_op}, {31'b0, vt[i].ill});
      if (vt[i].ev) begin
        chk($sformatf("v%0d_cmd", i), 32'(exe_cmd), 32'(vt[i].cmd));
        chk($sformatf("v%0d_val1", i), val1, vt[i].v1);
        chk($sformatf("v%0d_val2", i), val2, vt[i].v2);
        chk($sformatf("v%0d_dest", i), {27'b0, exe_dest}, {27'b0, vt[i].rd});
      end
      wb_clear(vt[i].rd);
      chk($sformatf("v%0d_illegal_gone", i), {31'b0, illegal_op}, 32'd0);
      chk($sformatf("v%0d_valid_gone", i), {31'b0, exe_valid}, 32'd0);
    end

    // RAW hazard on r3, released only the cycle after writeback
    exe_ready = 1'b1;
    instr = mk(6'h01, 5'd3, 5'd1, 16'h1000); rs1_data = 32'd5; rs2_data = 32'd7;
    instr_valid = 1'b1;
    tick();
    instr = mk(6'h02, 5'd5, 5'd3, 16'h0800); rs1_data = 32'd20; rs2_data = 32'd4;
    #1;
    chk("haz_ready_0", {31'b0, instr_ready}, 32'd0);
    tick();
    chk("haz_ready_1", {31'b0, instr_ready}, 32'd0);
    wb_valid = 1'b1; wb_addr = 5'd3;
    #1;
    chk("haz_no_bypass", {31'b0, instr_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("haz_released", {31'b0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("haz_sub_valid", {31'b0, exe_valid}, 32'd1);
    chk("haz_sub_cmd", 32'(exe_cmd), 32'(EXE_SUB));
    chk("haz_sub_val1", val1, 32'd20);
    chk("haz_sub_dest", {27'b0, exe_dest}, 32'd5);
    wb_clear(5'd5);

    // Backpressure: command held for 3 cycles, then next transfers immediately
    exe_ready = 1'b0;
    instr = mk(6'h01, 5'd6, 5'd1, 16'h1000); rs1_data = 32'h11; rs2_data = 32'h22;
    instr_valid = 1'b1;
    tick();
    instr = mk(6'h05, 5'd7, 5'd1, 16'h1000); rs1_data = 32'h33; rs2_data = 32'h44;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), {31'b0, instr_ready}, 32'd0);
      chk($sformatf("stall%0d_valid", c), {31'b0, exe_valid}, 32'd1);
      chk($sformatf("stall%0d_cmd", c), 32'(exe_cmd), 32'(EXE_ADD));
      chk($sformatf("stall%0d_val1", c), val1, 32'h11);
      chk($sformatf("stall%0d_val2", c), val2, 32'h22);
      chk($sformatf("stall%0d_dest", c), {27'b0, exe_dest}, 32'd6);
      tick();
    end
    exe_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'b0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("stall_next_valid", {31'b0, exe_valid}, 32'd1);
    chk("stall_next_cmd", 32'(exe_cmd), 32'(EXE_XOR));
    chk("stall_next_val1", val1, 32'h33);
    chk("stall_next_dest", {27'b0, exe_dest}, 32'd7);
    wb_clear(5'd6);
    wb_clear(5'd7);

    // Reset with a held command and r3 pending
    exe_ready = 1'b0;
    instr = mk(6'h02, 5'd3, 5'd1, 16'h1000); rs1_data = 32'd9; rs2_data = 32'd1;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("rr_held_valid", {31'b0, exe_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_valid", {31'b0, exe_valid}, 32'd0);
    chk("rr_cmd", 32'(exe_cmd), 32'(EXE_ADD));
    chk("rr_val1", val1, 32'd0);
    chk("rr_dest", {27'b0, exe_dest}, 32'd0);
    instr = mk(6'h02, 5'd5, 5'd3, 16'h0800); exe_ready = 1'b1; instr_valid = 1'b1;
    #1;
    chk("rr_r3_free", {31'b0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("rr_sub_valid", {31'b0, exe_valid}, 32'd1);
    wb_clear(5'd5);

    // Random traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_vld = 1'b0; m_ill = 1'b0; m_cmd = EXE_ADD; m_v1 = '0; m_v2 = '0; m_dest = '0;
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      op  = ops[$urandom_range(0, 20)];
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      lo  = 16'($urandom);
      k   = kind[op];
      if (k == 2) lo[15:14] = 2'b00;
      rs2 = lo[15:11];
      instr       = mk(op, rd, rs1, lo);
      rs1_data    = $urandom;
      rs2_data    = $urandom;
      instr_valid = ($urandom_range(0, 9) < 8);
      exe_ready   = ($urandom_range(0, 9) < 7);
      wb_valid    = ($urandom_range(0, 9) < 3);
      wb_addr     = 5'($urandom_range(0, 7));
      #1;
      haz = pend[rs1] || (k == 2 && pend[rs2]) || pend[rd];
      rdy = !haz && (!m_vld || exe_ready);
      acc = instr_valid && rdy;
      chk("rnd_ready", {31'b0, instr_ready}, {31'b0, rdy});
      chk("rnd_rs2_addr", {27'b0, rs2_addr}, {27'b0, rs2});

      m_ill = acc && (k == 0);
      if (wb_valid) pend[wb_addr] = 1'b0;
      if (acc && k >= 2) begin
        m_vld  = 1'b1;
        m_cmd  = cmdtab[op];
        m_v1   = (rs1 == 0) ? 32'd0 : rs1_data;
        m_dest = rd;
        case (k)
          2: m_v2 = (rs2 == 0) ? 32'd0 : rs2_data;
          3: m_v2 = lo[15] ? 32'(lo) - 32'h10000 : 32'(lo);
          4: m_v2 = 32'(lo);
          default: m_v2 = 32'(lo) % 32;
        endcase
        if (rd != 0) pend[rd] = 1'b1;
      end else if (m_vld && exe_ready) begin
        m_vld = 1'b0;
      end

      tick();
      chk("rnd_exe_valid", {31'b0, exe_valid}, {31'b0, m_vld});
      chk("rnd_illegal", {31'b0, illegal_op}, {31'b0, m_ill});
      if (m_vld) begin
        chk("rnd_cmd", 32'(exe_cmd), 32'(m_cmd));
        chk("rnd_val1", val1, m_v1);
        chk("rnd_val2", val2, m_v2);
        chk("rnd_dest", {27'b0, exe_dest}, {27'b0, m_dest});
      end
    end
    instr_valid = 1'b0;
    wb_valid    = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
